// File: rtl/wf_pending_tracker_pkg.sv
// Shared issue-stage definitions for the per-wavefront pending-instruction tracker.
package wf_pending_tracker_pkg;

  localparam int WF_ID_W          = 6;
  localparam int NUM_WF_DEFAULT   = 40;
  localparam int WF_PENDING_CNT_W = 4;

  typedef logic [WF_ID_W-1:0] wfid_t;

endpackage

// File: rtl/wf_pending_counter.sv
// One saturating up/down/clear pending counter; updates 1 cycle after inputs, never stalls.
// ovf/udf event detection exists only when WF_PENDING_ERR_EN is defined.
module wf_pending_counter
  import wf_pending_tracker_pkg::*;
#(
  parameter int CNT_W = WF_PENDING_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             is_zero,
  output logic             is_full,
  output logic             went_zero,
  output logic             ovf,
  output logic             udf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic up;
  logic dn;

  assign is_zero = (count == '0);
  assign is_full = (count == CNT_MAX);

  // Issue and completion together cancel; clear overrides both.
  assign up        = inc & ~dec & ~clr & ~is_full;
  assign dn        = dec & ~inc & ~clr & ~is_zero;
  assign went_zero = dn & (count == CNT_ONE);

`ifdef WF_PENDING_ERR_EN
  assign ovf = inc & ~dec & ~clr & is_full;
  assign udf = dec & ~inc & ~clr & is_zero;
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (up) begin
      count <= count + CNT_ONE;
    end else if (dn) begin
      count <= count - CNT_ONE;
    end
  end

endmodule

// File: rtl/wf_pending_tracker.sv
// Per-wavefront outstanding long-latency instruction tracker; state/drain/errors 1 cycle after inputs.
// No back-pressure: all inputs consumed every cycle. Sticky error flags built under WF_PENDING_ERR_EN.
module wf_pending_tracker
  import wf_pending_tracker_pkg::*;
#(
  parameter int NUM_WF = NUM_WF_DEFAULT,
  parameter int CNT_W  = WF_PENDING_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  wfid_t             issue_wfid,
  input  logic              muxed_wfid_done,
  input  wfid_t             muxed_wfid,
  input  logic              clear_valid,
  input  wfid_t             clear_wfid,
  output logic [NUM_WF-1:0] wf_idle,
  output logic [NUM_WF-1:0] wf_full,
  output logic              drain_valid,
  output wfid_t             drain_wfid,
  output logic              err_overflow,
  output logic              err_underflow
);

  logic [NUM_WF-1:0]            inc_vec;
  logic [NUM_WF-1:0]            dec_vec;
  logic [NUM_WF-1:0]            clr_vec;
  logic [NUM_WF-1:0]            wz_vec;
  logic [NUM_WF-1:0]            ovf_vec;
  logic [NUM_WF-1:0]            udf_vec;
  logic [NUM_WF-1:0][CNT_W-1:0] cnt;
  wfid_t                        drain_nxt;

  // Valid is ANDed first so an X wfid with its valid low decodes to 0.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    clr_vec = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      inc_vec[i] = issue_valid     && (issue_wfid == WF_ID_W'(i));
      dec_vec[i] = muxed_wfid_done && (muxed_wfid == WF_ID_W'(i));
      clr_vec[i] = clear_valid     && (clear_wfid == WF_ID_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_WF; g++) begin : g_cnt
    wf_pending_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc_vec[g]),
      .dec       (dec_vec[g]),
      .clr       (clr_vec[g]),
      .count     (cnt[g]),
      .is_zero   (wf_idle[g]),
      .is_full   (wf_full[g]),
      .went_zero (wz_vec[g]),
      .ovf       (ovf_vec[g]),
      .udf       (udf_vec[g])
    );
  end

  // Only one completion per cycle, so at most one bit is set; lowest index wins regardless.
  always_comb begin
    drain_nxt = '0;
    for (int i = NUM_WF - 1; i >= 0; i--) begin
      if (wz_vec[i]) drain_nxt = WF_ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drain_valid <= 1'b0;
      drain_wfid  <= '0;
    end else begin
      drain_valid <= |wz_vec;
      drain_wfid  <= drain_nxt;
    end
  end

`ifdef WF_PENDING_ERR_EN
  logic range_udf;
  assign range_udf = muxed_wfid_done && (muxed_wfid >= WF_ID_W'(NUM_WF));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      err_overflow  <= err_overflow | (|ovf_vec);
      err_underflow <= err_underflow | (|udf_vec) | range_udf;
    end
  end

  wire unused_ok = &{1'b0, cnt};
`else
  assign err_overflow  = 1'b0;
  assign err_underflow = 1'b0;

  wire unused_ok = &{1'b0, cnt, ovf_vec, udf_vec};
`endif

endmodule
